// File: rtl/sysreg_write_buffer_pkg.sv
// Shared definitions for the system-register write buffer: address width,
// system-register address map and the buffered entry record.
package sysreg_write_buffer_pkg;

   localparam int SYSREG_AW = 5;
   localparam int SYSREG_DW = 32;

   localparam logic [SYSREG_AW-1:0] SR_STATUS  = 5'd0;
   localparam logic [SYSREG_AW-1:0] SR_CAUSE   = 5'd1;
   localparam logic [SYSREG_AW-1:0] SR_EPC     = 5'd2;
   localparam logic [SYSREG_AW-1:0] SR_TVEC    = 5'd3;
   localparam logic [SYSREG_AW-1:0] SR_SCRATCH = 5'd4;
   localparam logic [SYSREG_AW-1:0] SR_IE      = 5'd5;
   localparam logic [SYSREG_AW-1:0] SR_IP      = 5'd6;
   localparam logic [SYSREG_AW-1:0] SR_TIMECMP = 5'd7;

   typedef struct packed {
      logic [SYSREG_AW-1:0] addr;
      logic [SYSREG_DW-1:0] data;
   } sysregEntry_t;

endpackage

// File: rtl/sysreg_write_buffer_lookup.sv
// Age-ordered newest-match search over the buffered writes plus the output register.
module sysreg_write_buffer_lookup
   import sysreg_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = SYSREG_AW
) (
   input  logic [DEPTH-1:0]     iValidAged,
   input  logic [AW-1:0]        iAddrAged [DEPTH],
   input  logic [SYSREG_DW-1:0] iDataAged [DEPTH],
   input  logic                 iRegValid,
   input  logic [AW-1:0]        iRegAddr,
   input  logic [SYSREG_DW-1:0] iRegData,
   input  logic [AW-1:0]        iLookupAddr,
   output logic                 oHit,
   output logic [SYSREG_DW-1:0] oData
);

   // Index 0 is the oldest entry; later matches overwrite earlier ones so the newest wins.
   always_comb begin
      oHit  = 1'b0;
      oData = '0;
      if (iRegValid && (iRegAddr == iLookupAddr)) begin
         oHit  = 1'b1;
         oData = iRegData;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (iValidAged[i] && (iAddrAged[i] == iLookupAddr)) begin
            oHit  = 1'b1;
            oData = iDataAged[i];
         end
      end
   end

endmodule

// File: rtl/sysreg_write_buffer.sv
// Speculative system-register write buffer: holds writes until commit or flush,
// drains committed writes in order onto a registered write port.
module sysreg_write_buffer
   import sysreg_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = SYSREG_AW
) (
   input  logic                 iCLOCK,
   input  logic                 iRESET_SYNC,
   input  logic                 iWR_VALID,
   input  logic [AW-1:0]        iWR_ADDR,
   input  logic [SYSREG_DW-1:0] iWR_DATA,
   output logic                 oWR_FULL,
   input  logic                 iCOMMIT,
   input  logic                 iFLUSH,
   input  logic                 iDRAIN_HOLD,
   output logic                 oREGIST_DATA_VALID,
   output logic [AW-1:0]        oREGIST_ADDR,
   output logic [SYSREG_DW-1:0] oREGIST_DATA,
   input  logic [AW-1:0]        iLOOKUP_ADDR,
   output logic                 oLOOKUP_HIT,
   output logic [SYSREG_DW-1:0] oLOOKUP_DATA,
   output logic                 oEMPTY,
   output logic                 oOVERFLOW
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]        head, cmt, tail;
   logic [PW-1:0]        committedCnt, uncommittedCnt, occupancy, cmtNext;
   logic [AW-1:0]        entryAddr [DEPTH];
   logic [SYSREG_DW-1:0] entryData [DEPTH];
   logic                 pushOk, pushDrop, commitOk, commitDrop, drainOk;

   logic [DEPTH-1:0]     validAged;
   logic [AW-1:0]        addrAged [DEPTH];
   logic [SYSREG_DW-1:0] dataAged [DEPTH];

   // Push handshake: iWR_VALID is the request, !oWR_FULL the ready; a write transfers
   // only on an edge where both hold. Full comes from registered pointers only, so a
   // same-cycle drain never makes room for a push.
   always_comb begin
      committedCnt   = cmt - head;
      uncommittedCnt = tail - cmt;
      occupancy      = tail - head;
      pushOk         = iWR_VALID && !oWR_FULL;
      pushDrop       = iWR_VALID && oWR_FULL;
      commitOk       = iCOMMIT && (uncommittedCnt != '0);
      commitDrop     = iCOMMIT && (uncommittedCnt == '0);
      drainOk        = (committedCnt != '0) && !iDRAIN_HOLD;
      cmtNext        = commitOk ? cmt + PW'(1) : cmt;
   end

   assign oWR_FULL = (occupancy == PW'(DEPTH));
   assign oEMPTY   = (occupancy == '0) && !oREGIST_DATA_VALID;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         head               <= '0;
         cmt                <= '0;
         tail               <= '0;
         oREGIST_DATA_VALID <= 1'b0;
         oREGIST_ADDR       <= '0;
         oREGIST_DATA       <= '0;
         oOVERFLOW          <= 1'b0;
      end else begin
         if (drainOk) begin
            head         <= head + PW'(1);
            oREGIST_ADDR <= entryAddr[head[IW-1:0]];
            oREGIST_DATA <= entryData[head[IW-1:0]];
         end
         oREGIST_DATA_VALID <= drainOk;
         cmt                <= cmtNext;
         // Flush rolls tail back to the post-commit boundary, discarding this cycle's push too.
         if (iFLUSH) begin
            tail <= cmtNext;
         end else if (pushOk) begin
            tail <= tail + PW'(1);
         end
         if (pushDrop || commitDrop) begin
            oOVERFLOW <= 1'b1;
         end
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (pushOk) begin
         entryAddr[tail[IW-1:0]] <= iWR_ADDR;
         entryData[tail[IW-1:0]] <= iWR_DATA;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         validAged[i] = (PW'(i) < occupancy);
         addrAged[i]  = entryAddr[head[IW-1:0] + IW'(i)];
         dataAged[i]  = entryData[head[IW-1:0] + IW'(i)];
      end
   end

   sysreg_write_buffer_lookup #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) uLookup (
      .iValidAged (validAged),
      .iAddrAged  (addrAged),
      .iDataAged  (dataAged),
      .iRegValid  (oREGIST_DATA_VALID),
      .iRegAddr   (oREGIST_ADDR),
      .iRegData   (oREGIST_DATA),
      .iLookupAddr(iLOOKUP_ADDR),
      .oHit       (oLOOKUP_HIT),
      .oData      (oLOOKUP_DATA)
   );

endmodule

// File: tb/tb_sysreg_write_buffer.sv
// Bench for sysreg_write_buffer: queue-based reference model, strobe scoreboard,
// directed scenarios followed by random traffic.
module tb_sysreg_write_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int W     = AW + 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } ent_t;

   logic          iCLOCK = 1'b0;
   logic          iRESET_SYNC = 1'b1;
   logic          iWR_VALID = 1'b0;
   logic [AW-1:0] iWR_ADDR = '0;
   logic [31:0]   iWR_DATA = '0;
   logic          iCOMMIT = 1'b0;
   logic          iFLUSH = 1'b0;
   logic          iDRAIN_HOLD = 1'b0;
   logic [AW-1:0] iLOOKUP_ADDR = '0;
   logic          oWR_FULL, oREGIST_DATA_VALID, oLOOKUP_HIT, oEMPTY, oOVERFLOW;
   logic [AW-1:0] oREGIST_ADDR;
   logic [31:0]   oREGIST_DATA, oLOOKUP_DATA;

   sysreg_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
      .iWR_VALID(iWR_VALID), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .oWR_FULL(oWR_FULL),
      .iCOMMIT(iCOMMIT), .iFLUSH(iFLUSH), .iDRAIN_HOLD(iDRAIN_HOLD),
      .oREGIST_DATA_VALID(oREGIST_DATA_VALID), .oREGIST_ADDR(oREGIST_ADDR), .oREGIST_DATA(oREGIST_DATA),
      .iLOOKUP_ADDR(iLOOKUP_ADDR), .oLOOKUP_HIT(oLOOKUP_HIT), .oLOOKUP_DATA(oLOOKUP_DATA),
      .oEMPTY(oEMPTY), .oOVERFLOW(oOVERFLOW)
   );

   always #5 iCLOCK = ~iCLOCK;

   // Reference model: committed and uncommitted writes as plain FIFOs.
   ent_t          cq[$];
   ent_t          uq[$];
   logic          mOutValid = 1'b0;
   ent_t          mOut = '0;
   logic          mOvf = 1'b0;
   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_lookup(input logic [AW-1:0] a, output logic hit, output logic [31:0] d);
      ent_t all[$];
      hit = 1'b0;
      d   = '0;
      if (mOutValid) all.push_back(mOut);
      foreach (cq[i]) all.push_back(cq[i]);
      foreach (uq[i]) all.push_back(uq[i]);
      for (int i = all.size() - 1; i >= 0; i--) begin
         if (all[i].addr == a) begin
            hit = 1'b1;
            d   = all[i].data;
            break;
         end
      end
   endfunction

   function automatic void model_edge();
      int   c, u;
      logic full;
      ent_t e;
      if (iRESET_SYNC) begin
         cq.delete();
         uq.delete();
         exp_q.delete();
         mOutValid = 1'b0;
         mOut      = '0;
         mOvf      = 1'b0;
         return;
      end
      c    = cq.size();
      u    = uq.size();
      full = (c + u) == DEPTH;
      if (c > 0 && !iDRAIN_HOLD) begin
         mOut      = cq.pop_front();
         mOutValid = 1'b1;
         exp_q.push_back({mOut.addr, mOut.data});
      end else begin
         mOutValid = 1'b0;
      end
      if (iCOMMIT) begin
         if (u > 0) begin
            e = uq.pop_front();
            cq.push_back(e);
         end else begin
            mOvf = 1'b1;
         end
      end
      if (iWR_VALID) begin
         if (!full) uq.push_back('{iWR_ADDR, iWR_DATA});
         else mOvf = 1'b1;
      end
      if (iFLUSH) uq.delete();
   endfunction

   task automatic check_status();
      logic        hit;
      logic [31:0] d;
      int          occ;
      occ = cq.size() + uq.size();
      model_lookup(iLOOKUP_ADDR, hit, d);
      check("full", oWR_FULL, occ == DEPTH);
      check("empty", oEMPTY, (occ == 0) && !mOutValid);
      check("overflow", oOVERFLOW, mOvf);
      check("strobe_valid", oREGIST_DATA_VALID, mOutValid);
      check("out_reg", {oREGIST_ADDR, oREGIST_DATA}, {mOut.addr, mOut.data});
      check("lookup_hit", oLOOKUP_HIT, hit);
      check("lookup_data", oLOOKUP_DATA, d);
   endtask

   task automatic step();
      @(negedge iCLOCK);
      check_status();
      @(posedge iCLOCK);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic wv, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic c, input logic f, input logic h);
      iWR_VALID   = wv;
      iWR_ADDR    = a;
      iWR_DATA    = d;
      iCOMMIT     = c;
      iFLUSH      = f;
      iDRAIN_HOLD = h;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_step();
      iRESET_SYNC = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      iRESET_SYNC = 1'b0;
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected drain.
   always @(negedge iCLOCK) begin
      logic [W-1:0] e;
      if (oREGIST_DATA_VALID) begin
         if (exp_q.size() == 0) begin
            check("strobe_unexpected", {oREGIST_ADDR, oREGIST_DATA}, '0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_data", {oREGIST_ADDR, oREGIST_DATA}, e);
         end
      end
   end

   initial begin
      repeat (2) @(posedge iCLOCK);
      model_edge();
      #1;
      iRESET_SYNC = 1'b0;
      check("rst_empty", oEMPTY, 1);
      check("rst_full", oWR_FULL, 0);
      check("rst_valid", oREGIST_DATA_VALID, 0);

      // Basic path
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("basic_valid", oREGIST_DATA_VALID, 1);
      check("basic_addr", oREGIST_ADDR, 3);
      check("basic_data", oREGIST_DATA, 32'hDEAD_BEEF);
      check("basic_not_empty", oEMPTY, 0);
      idle(1);
      check("basic_empty_after", oEMPTY, 1);

      // Full and overflow
      for (int i = 0; i < DEPTH; i++) drive(1'b1, AW'(8 + i), $urandom, 1'b0, 1'b0, 1'b0);
      check("full_set", oWR_FULL, 1);
      drive(1'b1, 5'd12, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("overflow_set", oOVERFLOW, 1);
      iLOOKUP_ADDR = 5'd12;
      #1;
      check("dropped_lookup_miss", oLOOKUP_HIT, 0);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      idle(2);
      reset_step();

      // Flush with same-cycle push
      drive(1'b1, 5'd1, 32'hA1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd2, 32'hB2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd3, 32'hC3, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd4, 32'hD4, 1'b1, 1'b1, 1'b0);
      idle(3);
      iLOOKUP_ADDR = 5'd2;
      #1;
      check("flush_lookup_hit", oLOOKUP_HIT, 0);
      check("flush_lookup_data", oLOOKUP_DATA, 0);

      // Newest-value lookup
      iLOOKUP_ADDR = 5'd5;
      drive(1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd5, 32'h22, 1'b1, 1'b0, 1'b0);
      check("lookup_pending_newest", oLOOKUP_DATA, 32'h22);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("lookup_strobe_valid", oREGIST_DATA_VALID, 1);
      check("lookup_during_strobe", oLOOKUP_DATA, 32'h22);
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd5, 32'h22, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      check("lookup_flushed_hit", oLOOKUP_HIT, 1);
      check("lookup_flushed_data", oLOOKUP_DATA, 32'h11);
      idle(2);

      // Drain hold
      drive(1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         check("hold_no_strobe", oREGIST_DATA_VALID, 0);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("hold_release_1", {oREGIST_DATA_VALID, oREGIST_ADDR}, {1'b1, 5'd6});
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("hold_release_2", {oREGIST_DATA_VALID, oREGIST_ADDR}, {1'b1, 5'd7});
      idle(1);
      check("hold_done", oREGIST_DATA_VALID, 0);

      // Reset mid-operation with two committed entries and a strobe due
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 5'd10, 32'hAA, 1'b1, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      iLOOKUP_ADDR = 5'd9;
      iRESET_SYNC  = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      iRESET_SYNC  = 1'b0;
      check("reset_valid", oREGIST_DATA_VALID, 0);
      check("reset_out", {oREGIST_ADDR, oREGIST_DATA}, 0);
      check("reset_overflow", oOVERFLOW, 0);
      check("reset_empty", oEMPTY, 1);
      check("reset_lookup", {oLOOKUP_HIT, oLOOKUP_DATA}, 0);
      idle(3);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         iLOOKUP_ADDR = AW'($urandom_range(0, 7));
         drive($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < 2 * DEPTH; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      idle(4);
      @(negedge iCLOCK);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sysreg_write_buffer.md
# sysreg_write_buffer

- Sits directly upstream of the system-register holding stage and absorbs speculative system-register writes from execute.
- Holds each write until retire commits it or a flush discards it.
- Drains committed writes in program order, one per cycle, onto the registered write port that the system-register stage captures.
- Provides newest-value lookup so dispatch can read a pending system-register value before it lands.

## Interface
Parameters:
- DEPTH, 4: number of buffer entries; a power of two, minimum 2.
- AW, 5: system-register address width.

Ports:
- iCLOCK  in  1  system clock; all state changes on its rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iWR_VALID  in  1  push one speculative write.
- iWR_ADDR  in  AW  target system-register address.
- iWR_DATA  in  32  write data.
- oWR_FULL  out  1  occupancy == DEPTH; a push is not accepted.
- iCOMMIT  in  1  commit the oldest uncommitted entry.
- iFLUSH  in  1  discard all uncommitted entries.
- iDRAIN_HOLD  in  1  stall the drain while high.
- oREGIST_DATA_VALID  out  1  registered one-cycle write strobe to the system-register stage.
- oREGIST_ADDR  out  AW  registered write address.
- oREGIST_DATA  out  32  registered write data.
- iLOOKUP_ADDR  in  AW  lookup address.
- oLOOKUP_HIT  out  1  a pending write exists for iLOOKUP_ADDR (combinational).
- oLOOKUP_DATA  out  32  data of the newest matching pending write; 0 when there is no hit.
- oEMPTY  out  1  no entries held and no write in flight on the output.
- oOVERFLOW  out  1  sticky flag: a push or commit was illegal.

## Operation
- **Ordering.** Circular buffer with three pointers, each log2(DEPTH)+1 bits wide: head (drain), cmt (commit boundary), tail (push).
  - Invariant: head ≤ cmt ≤ tail (modular).
  - Committed entries = cmt − head. Uncommitted entries = tail − cmt.
- **Push.** When iWR_VALID && !oWR_FULL: write {addr, data} at tail, then tail++. A push while full is dropped and sets oOVERFLOW.
- **Commit.** When iCOMMIT and uncommitted > 0 (counted at the start of the cycle): cmt++. A commit with no uncommitted entry is ignored and sets oOVERFLOW. A same-cycle push is never committed by that cycle's iCOMMIT.
- **Flush.** When iFLUSH: tail ← cmt, evaluated after that cycle's commit. The same-cycle push is discarded. Committed entries and the output register are unaffected.
- **Drain.** When committed > 0 (counted at the start of the cycle) and !iDRAIN_HOLD:
  - the output register loads the head entry and sets oREGIST_DATA_VALID = 1;
  - head++.
  - Otherwise oREGIST_DATA_VALID = 0 and addr/data hold their last value.
- **Lookup.** Search order, newest first: uncommitted entries, then committed entries, then the output register while oREGIST_DATA_VALID = 1. The first address match wins.
- **Simultaneous push + drain when full.** The push is still rejected; oWR_FULL is derived from the registered pointers only.
- **Reset.**
  - head, cmt and tail go to 0.
  - oREGIST_DATA_VALID, oREGIST_ADDR, oREGIST_DATA and oOVERFLOW go to 0.
  - oWR_FULL = 0, oEMPTY = 1, oLOOKUP_HIT = 0, oLOOKUP_DATA = 0.
  - Reset mid-operation discards every entry, including a pending output write; no strobe is issued afterwards.

## Timing
- Push at edge E0 → the entry is visible to lookup in the cycle after E0.
- The earliest commit is sampled at edge E1 = E0 + 1.
- oREGIST_DATA_VALID is high in the cycle after edge E1 + 1. Minimum push-to-strobe latency is 2 edges.
- Drain throughput is 1 entry per cycle. Back-to-back commits produce back-to-back strobes.
- oWR_FULL deasserts the cycle after the drain edge that frees a slot.
- oLOOKUP_* are purely combinational from registered state plus iLOOKUP_ADDR.
- iDRAIN_HOLD takes effect at the same edge it is sampled.

## Structure
- Shared package/include holds:
  - the system-register address width;
  - the address constants of the system registers;
  - the entry record: addr AW + data 32.
- Sub-module sysreg_write_buffer_lookup: age-ordered priority match over DEPTH entries plus the output register. Input is the valid-entry mask rotated to the head pointer.

## Test plan
- **Basic path.** Push addr 3/data 0xDEAD_BEEF, commit next cycle → a single strobe with addr 3, data 0xDEADBEEF two edges after the push; oEMPTY returns to 1 one cycle later.
- **Full.** Push 4 entries without commit → oWR_FULL = 1. A 5th push is dropped and sets oOVERFLOW = 1. Commit all 4 → 4 consecutive strobes in push order.
- **Flush.** Push A (addr 1), B (addr 2), C (addr 3); commit once, then flush in the same cycle as push D → only A is strobed. Lookup of addr 2 misses afterwards.
- **Lookup.** Push addr 5 = 0x11, commit, push addr 5 = 0x22 → lookup addr 5 returns 0x22 while both are pending. During A's strobe cycle it returns 0x22, and 0x11 only if the second write is flushed.
- **Hold.** Commit 2 entries with iDRAIN_HOLD = 1 for 3 cycles → no strobe; the strobes follow on the 2 cycles after release.
- **Reset.** Assert iRESET_SYNC with 2 committed entries and a strobe pending → all outputs read their reset values next cycle, and no strobe appears afterwards.
